// File: rtl/wbi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wbi_pkg
//  Description : Shared types for the daisy-chained WB interconnect nodes.
//                Command and response records, local FSM states and the
//                address-decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package wbi_pkg;

    localparam int WBI_AW = 32;
    localparam int WBI_BW = 4;
    localparam int WBI_BL = 10;
    localparam int WBI_DW = 32;
    localparam int WBI_TW = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } fsm_e;

    typedef struct packed {
        logic [WBI_AW-1:0] adr;
        logic              we;
        logic [WBI_DW-1:0] dat;
        logic [WBI_BW-1:0] sel;
        logic [WBI_TW-1:0] tid;
        logic [WBI_BL-1:0] bl;
    } cmd_t;

    typedef struct packed {
        logic [WBI_DW-1:0] dat;
        logic              ack;
        logic              lack;
        logic              err;
        logic [WBI_TW-1:0] tid;
    } res_t;

    function automatic logic addr_hit(input logic [WBI_AW-1:0] adr,
                                      input logic [WBI_AW-1:0] base,
                                      input logic [WBI_AW-1:0] mask);
        return (adr & mask) == base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wbi_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : wbi_arb2
//  Description : Two-way round-robin grant. When both request, the source
//                that was not granted last wins.
//  Ports       : req[1:0] requests, last = index of last granted source,
//                gnt[1:0] one-hot grant (zero when no request).
//  Revision    : 1.0  initial release
// ============================================================================
module wbi_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wbi_res_merge.sv
`default_nettype none
// ============================================================================
//  Module      : wbi_res_merge
//  Description : Merges local and downstream response streams into one
//                registered upstream response. Round-robin between sources,
//                locked to one source from a burst's first beat to its
//                lack beat.
//  Ports       : clk/rst_n, en (ready gating after reset),
//                loc_vld_i/loc_res_i + loc_take_o   local slot
//                dn_vld_i/dn_res_i + dn_take_o      downstream chain
//                out_vld_o/out_res_o + out_rdy_i    upstream chain
//  Revision    : 1.0  initial release
// ============================================================================
module wbi_res_merge
    import wbi_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic loc_vld_i,
    input  res_t loc_res_i,
    input  logic dn_vld_i,
    input  res_t dn_res_i,
    input  logic out_rdy_i,
    output logic loc_take_o,
    output logic dn_take_o,
    output logic out_vld_o,
    output res_t out_res_o
);

    logic out_vld_q, out_vld_d;
    res_t out_res_q, out_res_d;
    logic lock_q, lock_d;
    logic lock_src_q, lock_src_d;   // 0 = local, 1 = downstream
    logic last_q, last_d;

    logic [1:0] arb_gnt;
    logic [1:0] gnt;
    logic       loadable;
    res_t       sel_res;

    wbi_arb2 u_arb (
        .req  ({dn_vld_i, loc_vld_i}),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    always_comb begin
        // Register accepts a new beat when empty or draining this cycle.
        loadable = !out_vld_q || out_rdy_i;

        if (lock_q) begin
            gnt = lock_src_q ? {dn_vld_i, 1'b0} : {1'b0, loc_vld_i};
        end else begin
            gnt = arb_gnt;
        end

        loc_take_o = gnt[0] && loadable;
        dn_take_o  = gnt[1] && loadable && en;
        sel_res    = dn_take_o ? dn_res_i : loc_res_i;

        out_vld_d  = out_vld_q;
        out_res_d  = out_res_q;
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        last_d     = last_q;

        if (loc_take_o || dn_take_o) begin
            out_vld_d  = 1'b1;
            out_res_d  = sel_res;
            last_d     = dn_take_o;
            lock_src_d = dn_take_o;
            lock_d     = !sel_res.lack;
        end else if (out_rdy_i) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_res_q  <= '0;
            lock_q     <= 1'b0;
            lock_src_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_res_q  <= out_res_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            last_q     <= last_d;
        end
    end

    assign out_vld_o = out_vld_q;
    assign out_res_o = out_res_q;

endmodule
`default_nettype wire

// File: rtl/wbi_slave_port.sv
`default_nettype none
// ============================================================================
//  Module      : wbi_slave_port
//  Description : Slave-side tap on the daisy-chained WB interconnect.
//                Address hits run on the local Wishbone slave; misses go to
//                the next node through a one-entry forward register. Local
//                and downstream responses merge onto the upstream chain.
//  Ports       : mclk/reset_n                 clock, async active-low reset
//                wbu_cmd_* / wbu_res_*        upstream command / response
//                wbn_cmd_* / wbn_res_*        next-node command / response
//                wbs_*                        local Wishbone slave
//  Revision    : 1.0  initial release
// ============================================================================
module wbi_slave_port
    import wbi_pkg::*;
#(
    parameter int            AW       = WBI_AW,
    parameter int            BW       = WBI_BW,
    parameter int            BL       = WBI_BL,
    parameter int            DW       = WBI_DW,
    parameter logic [AW-1:0] SLV_BASE = 32'h3000_0000,
    parameter logic [AW-1:0] SLV_MASK = 32'hF000_0000
) (
    input  logic          mclk,
    input  logic          reset_n,
    output logic          wbu_cmd_wrdy_o,
    input  logic          wbu_cmd_wval_i,
    input  logic [AW-1:0] wbu_cmd_adr_i,
    input  logic          wbu_cmd_we_i,
    input  logic [DW-1:0] wbu_cmd_dat_i,
    input  logic [BW-1:0] wbu_cmd_sel_i,
    input  logic [3:0]    wbu_cmd_tid_i,
    input  logic [BL-1:0] wbu_cmd_bl_i,
    input  logic          wbu_res_rrdy_i,
    output logic          wbu_res_rval_o,
    output logic [DW-1:0] wbu_res_dat_o,
    output logic          wbu_res_ack_o,
    output logic          wbu_res_lack_o,
    output logic          wbu_res_err_o,
    output logic [3:0]    wbu_res_tid_o,
    input  logic          wbn_cmd_wrdy_i,
    output logic          wbn_cmd_wval_o,
    output logic [AW-1:0] wbn_cmd_adr_o,
    output logic          wbn_cmd_we_o,
    output logic [DW-1:0] wbn_cmd_dat_o,
    output logic [BW-1:0] wbn_cmd_sel_o,
    output logic [3:0]    wbn_cmd_tid_o,
    output logic [BL-1:0] wbn_cmd_bl_o,
    output logic          wbn_res_rrdy_o,
    input  logic          wbn_res_rval_i,
    input  logic [DW-1:0] wbn_res_dat_i,
    input  logic          wbn_res_ack_i,
    input  logic          wbn_res_lack_i,
    input  logic          wbn_res_err_i,
    input  logic [3:0]    wbn_res_tid_i,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    output logic          wbs_we_o,
    output logic [AW-1:0] wbs_adr_o,
    output logic [DW-1:0] wbs_dat_o,
    output logic [BW-1:0] wbs_sel_o,
    output logic [BL-1:0] wbs_bl_o,
    output logic          wbs_bry_o,
    input  logic [DW-1:0] wbs_dat_i,
    input  logic          wbs_ack_i,
    input  logic          wbs_lack_i,
    input  logic          wbs_err_i
);

    localparam logic [BL-1:0] BEAT_ONE = BL'(1);

    // Ready outputs are gated until the first clock after reset so that
    // every output reads 0 while reset is held.
    logic out_en_q, out_en_d;

    cmd_t cmd_in;
    logic hit, fwd_free, cmd_xfer;

    logic fwd_vld_q, fwd_vld_d;
    cmd_t fwd_cmd_q, fwd_cmd_d;

    fsm_e          state_q, state_d;
    cmd_t          req_q, req_d;
    logic [BL-1:0] beat_cnt_q, beat_cnt_d;
    logic          loc_vld_q, loc_vld_d;
    res_t          loc_res_q, loc_res_d;
    logic          beat, beat_last, loc_take, dn_take;

    res_t dn_res, out_res;
    logic out_vld;

    assign cmd_in = '{adr: wbu_cmd_adr_i, we: wbu_cmd_we_i, dat: wbu_cmd_dat_i,
                      sel: wbu_cmd_sel_i, tid: wbu_cmd_tid_i, bl: wbu_cmd_bl_i};

    // ---------------- command decode / forward register ----------------
    assign hit            = addr_hit(wbu_cmd_adr_i, SLV_BASE, SLV_MASK);
    assign fwd_free       = !fwd_vld_q || wbn_cmd_wrdy_i;
    assign wbu_cmd_wrdy_o = out_en_q && (hit ? (state_q == IDLE) : fwd_free);
    assign cmd_xfer       = wbu_cmd_wval_i && wbu_cmd_wrdy_o;
    assign out_en_d       = 1'b1;

    always_comb begin
        fwd_vld_d = fwd_vld_q;
        fwd_cmd_d = fwd_cmd_q;
        if (fwd_free) begin
            fwd_vld_d = cmd_xfer && !hit;
            if (cmd_xfer && !hit) begin
                fwd_cmd_d = cmd_in;
            end
        end
    end

    // ---------------- local FSM: next state ----------------
    assign beat      = (state_q == ACC) && (wbs_ack_i || wbs_err_i);
    assign beat_last = (beat_cnt_q == BEAT_ONE) || wbs_lack_i || wbs_err_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_xfer && hit)   state_d = ACC;
            ACC:     if (beat && beat_last) state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // ---------------- local FSM: outputs ----------------
    always_comb begin
        wbs_cyc_o = (state_q == ACC);
        wbs_stb_o = (state_q == ACC);
    end

    // ---------------- local request / response datapath ----------------
    always_comb begin
        req_d      = req_q;
        beat_cnt_d = beat_cnt_q;
        loc_vld_d  = loc_vld_q;
        loc_res_d  = loc_res_q;

        if ((state_q == IDLE) && cmd_xfer && hit) begin
            req_d = cmd_in;
            // Writes are a single beat; bl still goes to the slave as-is.
            beat_cnt_d = (cmd_in.we || (cmd_in.bl == '0)) ? BEAT_ONE : cmd_in.bl;
        end

        if (loc_take) begin
            loc_vld_d = 1'b0;
        end

        if (beat) begin
            loc_vld_d      = 1'b1;
            loc_res_d.dat  = req_q.we ? '0 : wbs_dat_i;
            loc_res_d.ack  = wbs_ack_i;
            loc_res_d.lack = beat_last;
            loc_res_d.err  = wbs_err_i;
            loc_res_d.tid  = req_q.tid;
            beat_cnt_d     = beat_cnt_q - BEAT_ONE;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            out_en_q   <= 1'b0;
            fwd_vld_q  <= 1'b0;
            fwd_cmd_q  <= '0;
            state_q    <= IDLE;
            req_q      <= '0;
            beat_cnt_q <= '0;
            loc_vld_q  <= 1'b0;
            loc_res_q  <= '0;
        end else begin
            out_en_q   <= out_en_d;
            fwd_vld_q  <= fwd_vld_d;
            fwd_cmd_q  <= fwd_cmd_d;
            state_q    <= state_d;
            req_q      <= req_d;
            beat_cnt_q <= beat_cnt_d;
            loc_vld_q  <= loc_vld_d;
            loc_res_q  <= loc_res_d;
        end
    end

    // The slave may only return a beat while the local slot is free.
    a_no_ack_when_full: assert property (@(posedge mclk) disable iff (!reset_n)
        beat |-> !loc_vld_q);

    // ---------------- response merge ----------------
    assign dn_res = '{dat: wbn_res_dat_i, ack: wbn_res_ack_i, lack: wbn_res_lack_i,
                      err: wbn_res_err_i, tid: wbn_res_tid_i};

    wbi_res_merge u_merge (
        .clk        (mclk),
        .rst_n      (reset_n),
        .en         (out_en_q),
        .loc_vld_i  (loc_vld_q),
        .loc_res_i  (loc_res_q),
        .dn_vld_i   (wbn_res_rval_i),
        .dn_res_i   (dn_res),
        .out_rdy_i  (wbu_res_rrdy_i),
        .loc_take_o (loc_take),
        .dn_take_o  (dn_take),
        .out_vld_o  (out_vld),
        .out_res_o  (out_res)
    );

    // ---------------- output mapping ----------------
    assign wbu_res_rval_o = out_vld;
    assign wbu_res_dat_o  = out_res.dat;
    assign wbu_res_ack_o  = out_res.ack;
    assign wbu_res_lack_o = out_res.lack;
    assign wbu_res_err_o  = out_res.err;
    assign wbu_res_tid_o  = out_res.tid;
    assign wbn_res_rrdy_o = dn_take;

    assign wbn_cmd_wval_o = fwd_vld_q;
    assign wbn_cmd_adr_o  = fwd_cmd_q.adr;
    assign wbn_cmd_we_o   = fwd_cmd_q.we;
    assign wbn_cmd_dat_o  = fwd_cmd_q.dat;
    assign wbn_cmd_sel_o  = fwd_cmd_q.sel;
    assign wbn_cmd_tid_o  = fwd_cmd_q.tid;
    assign wbn_cmd_bl_o   = fwd_cmd_q.bl;

    assign wbs_we_o  = req_q.we;
    assign wbs_adr_o = req_q.adr;
    assign wbs_dat_o = req_q.dat;
    assign wbs_sel_o = req_q.sel;
    assign wbs_bl_o  = req_q.bl;
    assign wbs_bry_o = out_en_q && !loc_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_wbi_slave_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wbi_slave_port
//  Description : Self-checking bench for wbi_slave_port. Directed scenarios
//                plus randomized mixed traffic, scored against a reference
//                model of per-source response streams and forwarded commands.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wbi_slave_port;
    import wbi_pkg::*;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic        wbu_cmd_wrdy_o, wbu_cmd_wval_i;
    logic [31:0] wbu_cmd_adr_i;
    logic        wbu_cmd_we_i;
    logic [31:0] wbu_cmd_dat_i;
    logic [3:0]  wbu_cmd_sel_i, wbu_cmd_tid_i;
    logic [9:0]  wbu_cmd_bl_i;
    logic        wbu_res_rrdy_i, wbu_res_rval_o;
    logic [31:0] wbu_res_dat_o;
    logic        wbu_res_ack_o, wbu_res_lack_o, wbu_res_err_o;
    logic [3:0]  wbu_res_tid_o;
    logic        wbn_cmd_wrdy_i, wbn_cmd_wval_o;
    logic [31:0] wbn_cmd_adr_o;
    logic        wbn_cmd_we_o;
    logic [31:0] wbn_cmd_dat_o;
    logic [3:0]  wbn_cmd_sel_o, wbn_cmd_tid_o;
    logic [9:0]  wbn_cmd_bl_o;
    logic        wbn_res_rrdy_o, wbn_res_rval_i;
    logic [31:0] wbn_res_dat_i;
    logic        wbn_res_ack_i, wbn_res_lack_i, wbn_res_err_i;
    logic [3:0]  wbn_res_tid_i;
    logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [31:0] wbs_adr_o, wbs_dat_o;
    logic [3:0]  wbs_sel_o;
    logic [9:0]  wbs_bl_o;
    logic        wbs_bry_o;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_i, wbs_lack_i, wbs_err_i;

    wbi_slave_port dut (
        .mclk(mclk), .reset_n(reset_n),
        .wbu_cmd_wrdy_o(wbu_cmd_wrdy_o), .wbu_cmd_wval_i(wbu_cmd_wval_i),
        .wbu_cmd_adr_i(wbu_cmd_adr_i), .wbu_cmd_we_i(wbu_cmd_we_i),
        .wbu_cmd_dat_i(wbu_cmd_dat_i), .wbu_cmd_sel_i(wbu_cmd_sel_i),
        .wbu_cmd_tid_i(wbu_cmd_tid_i), .wbu_cmd_bl_i(wbu_cmd_bl_i),
        .wbu_res_rrdy_i(wbu_res_rrdy_i), .wbu_res_rval_o(wbu_res_rval_o),
        .wbu_res_dat_o(wbu_res_dat_o), .wbu_res_ack_o(wbu_res_ack_o),
        .wbu_res_lack_o(wbu_res_lack_o), .wbu_res_err_o(wbu_res_err_o),
        .wbu_res_tid_o(wbu_res_tid_o),
        .wbn_cmd_wrdy_i(wbn_cmd_wrdy_i), .wbn_cmd_wval_o(wbn_cmd_wval_o),
        .wbn_cmd_adr_o(wbn_cmd_adr_o), .wbn_cmd_we_o(wbn_cmd_we_o),
        .wbn_cmd_dat_o(wbn_cmd_dat_o), .wbn_cmd_sel_o(wbn_cmd_sel_o),
        .wbn_cmd_tid_o(wbn_cmd_tid_o), .wbn_cmd_bl_o(wbn_cmd_bl_o),
        .wbn_res_rrdy_o(wbn_res_rrdy_o), .wbn_res_rval_i(wbn_res_rval_i),
        .wbn_res_dat_i(wbn_res_dat_i), .wbn_res_ack_i(wbn_res_ack_i),
        .wbn_res_lack_i(wbn_res_lack_i), .wbn_res_err_i(wbn_res_err_i),
        .wbn_res_tid_i(wbn_res_tid_i),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_bl_o(wbs_bl_o), .wbs_bry_o(wbs_bry_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i),
        .wbs_lack_i(wbs_lack_i), .wbs_err_i(wbs_err_i)
    );

    always #5 mclk = ~mclk;

    // ---------------- bookkeeping ----------------
    int   n_checks = 0;
    int   n_errors = 0;
    int   beats    = 0;
    res_t last_out;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    cmd_t cmd_q[$];      // commands waiting to be offered upstream
    cmd_t fwd_exp[$];    // misses accepted, expected at the next node
    res_t loc_exp[$];    // responses the local slave path must produce
    res_t dn_src[$];     // downstream beats still to be offered
    res_t dn_exp[$];     // downstream beats accepted by the DUT
    int   lk = 0;        // 0 free, 1 inside local burst, 2 inside downstream burst

    logic active = 1'b0; // stimulus processes idle while 0
    logic rnd_gap = 1'b0;
    int   err_beat = 0;  // slave answers err on this beat (1-based), 0 = never
    int   up_mode = 3;   // 0 random, 1 toggle, 2 hold off, 3 always ready
    int   nx_mode = 2;   // 0 random, 1 hold off, 2 always ready

    function automatic logic is_hit(input logic [31:0] a);
        return (a & 32'hF000_0000) == 32'h3000_0000;
    endfunction

    function automatic logic [31:0] slv_dat(input logic [31:0] a, input int i);
        return 32'hA5A5_0001 + (a - 32'h3000_0010) + (32'(i) << 20);
    endfunction

    // Response stream a hit command must produce, derived from its fields.
    task automatic model_hit(input cmd_t c);
        int   n;
        res_t r;
        n = c.we ? 1 : ((c.bl == 0) ? 1 : int'(c.bl));
        if (err_beat != 0 && err_beat <= n) n = err_beat;
        for (int i = 1; i <= n; i++) begin
            r.dat  = c.we ? 32'h0 : slv_dat(c.adr, i - 1);
            r.err  = (i == err_beat);
            r.ack  = !r.err;
            r.lack = (i == n);
            r.tid  = c.tid;
            loc_exp.push_back(r);
        end
    endtask

    // ---------------- upstream command driver ----------------
    logic a_hold = 1'b0;
    cmd_t a_cur;
    always begin
        @(negedge mclk);
        if (!active) begin
            wbu_cmd_wval_i = 1'b0;
            a_hold = 1'b0;
        end else begin
            if (!a_hold && cmd_q.size() > 0 && (!rnd_gap || $urandom_range(3) != 0)) begin
                a_cur  = cmd_q.pop_front();
                a_hold = 1'b1;
            end
            wbu_cmd_wval_i = a_hold;
            wbu_cmd_adr_i  = a_hold ? a_cur.adr : $urandom;
            wbu_cmd_we_i   = a_cur.we;
            wbu_cmd_dat_i  = a_cur.dat;
            wbu_cmd_sel_i  = a_cur.sel;
            wbu_cmd_tid_i  = a_cur.tid;
            wbu_cmd_bl_i   = a_cur.bl;
            #1;
            if (wbu_cmd_wval_i && wbu_cmd_wrdy_o) begin
                if (is_hit(a_cur.adr)) model_hit(a_cur);
                else                   fwd_exp.push_back(a_cur);
                a_hold = 1'b0;
            end
        end
    end

    // ---------------- local Wishbone slave ----------------
    int   s_cnt = 0;
    logic s_ackd = 1'b0;
    always begin
        @(negedge mclk);
        wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_lack_i = 1'b0;
        if (!wbs_cyc_o) s_cnt = 0;
        if (s_ackd && active) chk("bry_full", wbs_bry_o, 1'b0);
        s_ackd = 1'b0;
        if (active && wbs_cyc_o && wbs_stb_o && wbs_bry_o && $urandom_range(3) != 0) begin
            if (s_cnt + 1 == err_beat) wbs_err_i = 1'b1;
            else                       wbs_ack_i = 1'b1;
            wbs_dat_i = slv_dat(wbs_adr_o, s_cnt);
            s_cnt++;
            s_ackd = 1'b1;
        end
    end

    // ---------------- downstream response source ----------------
    logic c_hold = 1'b0;
    res_t c_cur;
    always begin
        @(negedge mclk);
        if (!active) begin
            wbn_res_rval_i = 1'b0;
            c_hold = 1'b0;
        end else begin
            if (!c_hold && dn_src.size() > 0 && $urandom_range(4) != 0) begin
                c_cur  = dn_src.pop_front();
                c_hold = 1'b1;
            end
            wbn_res_rval_i = c_hold;
            wbn_res_dat_i  = c_cur.dat;
            wbn_res_ack_i  = c_cur.ack;
            wbn_res_lack_i = c_cur.lack;
            wbn_res_err_i  = c_cur.err;
            wbn_res_tid_i  = c_cur.tid;
            #1;
            if (wbn_res_rval_i && wbn_res_rrdy_o) begin
                dn_exp.push_back(c_cur);
                c_hold = 1'b0;
            end
        end
    end

    // ---------------- upstream response sink / scoreboard ----------------
    res_t up_res, d_prev;
    logic d_stall = 1'b0;
    assign up_res = '{dat: wbu_res_dat_o, ack: wbu_res_ack_o, lack: wbu_res_lack_o,
                      err: wbu_res_err_o, tid: wbu_res_tid_o};
    always begin
        @(negedge mclk);
        case (up_mode)
            0:       wbu_res_rrdy_i = ($urandom_range(1) == 1);
            1:       wbu_res_rrdy_i = !wbu_res_rrdy_i;
            2:       wbu_res_rrdy_i = 1'b0;
            default: wbu_res_rrdy_i = 1'b1;
        endcase
        if (!active) begin
            d_stall = 1'b0;
        end else begin
            if (d_stall) chk("res_hold", {wbu_res_rval_o, up_res}, {1'b1, d_prev});
            if (wbu_res_rval_o) begin
                if (wbu_res_rrdy_i) begin
                    int src;
                    src = (lk == 1 || (lk == 0 && loc_exp.size() > 0 && loc_exp[0] == up_res)) ? 1 : 2;
                    if (src == 1) begin
                        if (loc_exp.size() == 0) chk("loc_unexpected", up_res, 0);
                        else                     chk("loc_beat", up_res, loc_exp.pop_front());
                    end else begin
                        if (dn_exp.size() == 0) chk("dn_unexpected", up_res, 0);
                        else                    chk("dn_beat", up_res, dn_exp.pop_front());
                    end
                    lk = up_res.lack ? 0 : src;
                    last_out = up_res;
                    beats++;
                end
                d_stall = !wbu_res_rrdy_i;
                d_prev  = up_res;
            end else begin
                d_stall = 1'b0;
            end
        end
    end

    // ---------------- next-node command sink ----------------
    cmd_t n_cmd, e_prev;
    logic e_stall = 1'b0;
    assign n_cmd = '{adr: wbn_cmd_adr_o, we: wbn_cmd_we_o, dat: wbn_cmd_dat_o,
                     sel: wbn_cmd_sel_o, tid: wbn_cmd_tid_o, bl: wbn_cmd_bl_o};
    always begin
        @(negedge mclk);
        case (nx_mode)
            0:       wbn_cmd_wrdy_i = ($urandom_range(2) != 0);
            1:       wbn_cmd_wrdy_i = 1'b0;
            default: wbn_cmd_wrdy_i = 1'b1;
        endcase
        if (!active) begin
            e_stall = 1'b0;
        end else begin
            if (e_stall) chk("fwd_hold", {wbn_cmd_wval_o, n_cmd}, {1'b1, e_prev});
            if (wbn_cmd_wval_o) begin
                if (wbn_cmd_wrdy_i) begin
                    if (fwd_exp.size() == 0) chk("fwd_unexpected", n_cmd, 0);
                    else                     chk("fwd_cmd", n_cmd, fwd_exp.pop_front());
                end
                e_stall = !wbn_cmd_wrdy_i;
                e_prev  = n_cmd;
            end else begin
                e_stall = 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic cmd_t mk_cmd(input logic [31:0] adr, input logic we,
                                    input logic [9:0] bl, input logic [3:0] tid);
        mk_cmd = '{adr: adr, we: we, dat: $urandom, sel: 4'($urandom), tid: tid, bl: bl};
    endfunction

    task automatic push_dn_burst(input int len, input logic [3:0] tid);
        res_t r;
        for (int i = 1; i <= len; i++) begin
            r = '{dat: $urandom, ack: 1'b1, lack: (i == len), err: 1'b0, tid: tid};
            dn_src.push_back(r);
        end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (t < 3000 && (cmd_q.size() != 0 || fwd_exp.size() != 0 || loc_exp.size() != 0 ||
               dn_src.size() != 0 || dn_exp.size() != 0 || a_hold || c_hold ||
               wbs_cyc_o || wbu_res_rval_o || wbn_cmd_wval_o)) begin
            @(negedge mclk);
            t++;
        end
        chk(tag, (t >= 3000), 1'b0);
        repeat (2) @(negedge mclk);
    endtask

    function automatic logic any_out();
        return |{wbu_cmd_wrdy_o, wbu_res_rval_o, wbu_res_dat_o, wbu_res_ack_o, wbu_res_lack_o,
                 wbu_res_err_o, wbu_res_tid_o, wbn_cmd_wval_o, wbn_cmd_adr_o, wbn_cmd_we_o,
                 wbn_cmd_dat_o, wbn_cmd_sel_o, wbn_cmd_tid_o, wbn_cmd_bl_o, wbn_res_rrdy_o,
                 wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o,
                 wbs_bl_o, wbs_bry_o};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int b0, t;
        logic [3:0] nb;
        reset_n = 1'b0;
        wbu_cmd_wval_i = 1'b0; wbu_cmd_adr_i = '0; wbu_cmd_we_i = 1'b0; wbu_cmd_dat_i = '0;
        wbu_cmd_sel_i = '0; wbu_cmd_tid_i = '0; wbu_cmd_bl_i = '0; wbu_res_rrdy_i = 1'b0;
        wbn_cmd_wrdy_i = 1'b0; wbn_res_rval_i = 1'b0; wbn_res_dat_i = '0; wbn_res_ack_i = 1'b0;
        wbn_res_lack_i = 1'b0; wbn_res_err_i = 1'b0; wbn_res_tid_i = '0;
        wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_lack_i = 1'b0; wbs_err_i = 1'b0;

        repeat (3) @(negedge mclk);
        #2 chk("reset_outputs", any_out(), 1'b0);
        @(negedge mclk);
        reset_n = 1'b1;
        active  = 1'b1;
        @(negedge mclk);

        // 1: single read hit
        b0 = beats;
        cmd_q.push_back(mk_cmd(32'h3000_0010, 1'b0, 10'd1, 4'd2));
        drain("t1_timeout");
        chk("t1_beats", beats - b0, 1);
        chk("t1_dat", last_out.dat, 32'hA5A5_0001);
        chk("t1_flags", {last_out.ack, last_out.lack, last_out.err, last_out.tid}, {3'b110, 4'd2});

        // 2: miss stalled by the next node
        nx_mode = 1;
        cmd_q.push_back(mk_cmd(32'h1000_0000, 1'b1, 10'd3, 4'd5));
        t = 0;
        while (fwd_exp.size() == 0 && t < 50) begin @(negedge mclk); #2; t++; end
        chk("t2_accept_timeout", (t >= 50), 1'b0);
        repeat (3) begin
            @(negedge mclk); #2;
            chk("t2_wval", {wbn_cmd_wval_o, wbn_cmd_adr_o}, {1'b1, 32'h1000_0000});
        end
        cmd_q.push_back(mk_cmd(32'h1000_0040, 1'b0, 10'd0, 4'd6));
        repeat (3) begin
            @(negedge mclk); #2;
            chk("t2_wrdy_stall", {wbu_cmd_wval_i, wbu_cmd_wrdy_o}, 2'b10);
        end
        nx_mode = 2;
        drain("t2_timeout");

        // 3: read burst with toggling upstream ready
        up_mode = 1;
        b0 = beats;
        cmd_q.push_back(mk_cmd(32'h3000_0100, 1'b0, 10'd4, 4'd3));
        drain("t3_timeout");
        chk("t3_beats", beats - b0, 4);

        // 4: local and downstream bursts pending together
        up_mode = 2;
        b0 = beats;
        push_dn_burst(2, 4'd9);
        cmd_q.push_back(mk_cmd(32'h3000_0180, 1'b0, 10'd2, 4'd4));
        repeat (20) @(negedge mclk);
        up_mode = 3;
        drain("t4_timeout");
        chk("t4_beats", beats - b0, 4);

        // 5: error on beat 2 of a 4-beat read, then a write hit
        b0 = beats;
        err_beat = 2;
        cmd_q.push_back(mk_cmd(32'h3000_0200, 1'b0, 10'd4, 4'd6));
        drain("t5_timeout");
        chk("t5_err_beat", {last_out.err, last_out.lack, beats - b0}, {2'b11, 32'd2});
        err_beat = 0;
        cmd_q.push_back(mk_cmd(32'h3000_0240, 1'b1, 10'd3, 4'd7));
        drain("t5_next_timeout");
        chk("t5_next_beats", beats - b0, 3);

        // randomized mixed traffic
        rnd_gap = 1; up_mode = 0; nx_mode = 0;
        b0 = beats;
        for (int i = 0; i < 70; i++) begin
            if ($urandom_range(1) == 1) begin
                cmd_q.push_back(mk_cmd(32'h3000_0000 | ($urandom & 32'h0FFF_FFF0),
                                       1'($urandom), 10'($urandom_range(5)), 4'($urandom)));
            end else begin
                do nb = 4'($urandom); while (nb == 4'h3);
                cmd_q.push_back(mk_cmd({nb, 28'($urandom)}, 1'($urandom),
                                       10'($urandom_range(5)), 4'($urandom)));
            end
            if ($urandom_range(2) == 0) push_dn_burst($urandom_range(1, 3), 4'($urandom));
            if ($urandom_range(3) == 0) repeat ($urandom_range(6)) @(negedge mclk);
        end
        drain("rand_timeout");
        chk("rand_some_beats", (beats - b0 > 20), 1'b1);

        // 6: reset in the middle of a burst
        rnd_gap = 0; up_mode = 3; nx_mode = 2;
        cmd_q.push_back(mk_cmd(32'h3000_0300, 1'b0, 10'd4, 4'd1));
        t = 0;
        while (!(wbs_cyc_o && s_cnt >= 1) && t < 100) begin @(negedge mclk); #2; t++; end
        chk("t6_burst_timeout", (t >= 100), 1'b0);
        #1;
        active  = 1'b0;
        reset_n = 1'b0;
        #1 chk("t6_async_reset", any_out(), 1'b0);
        cmd_q.delete(); fwd_exp.delete(); loc_exp.delete(); dn_src.delete(); dn_exp.delete();
        lk = 0;
        repeat (3) @(negedge mclk);
        chk("t6_reset_hold", any_out(), 1'b0);
        reset_n = 1'b1;
        active  = 1'b1;
        b0 = beats;
        cmd_q.push_back(mk_cmd(32'h3000_0010, 1'b0, 10'd1, 4'd8));
        drain("t6_timeout");
        chk("t6_after_reset", {beats - b0, last_out.dat, last_out.tid}, {32'd1, 32'hA5A5_0001, 4'd8});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
